// File: rtl/adc_pkg.sv
// Shared constants for the ADC averaging filter.
//   DW     - default ADC sample width
//   LOG2N  - default log2 of the averaging window depth
//   SUM_W  - width of the running window sum (cannot overflow)
//   FILL/RUN - filter FSM state encodings
package adc_pkg;

    localparam int DW    = 11;
    localparam int LOG2N = 3;
    localparam int SUM_W = DW + LOG2N;

    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

endpackage

// File: rtl/tick_edge_det.sv
// Tick edge detector: registers a tick/strobe input and flags its rising edge.
//   clk    - clock
//   rst_n  - asynchronous active-low reset
//   tick   - level input (may stay high for several cycles)
//   tick_q - tick delayed by one cycle
//   rise   - combinational pulse, high in the first cycle tick is seen high
module tick_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    output logic tick_q,
    output logic rise
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick;
        end
    end

    assign rise = tick & ~tick_q;

endmodule

// File: rtl/adc_avg_filter.sv
// Moving-average filter over the last N = 2**LOG2N accepted ADC samples.
//   clk        - clock, all state on rising edge
//   rst        - asynchronous active-low reset
//   din        - ADC sample, valid while din_tick is high
//   din_tick   - sample-ready level from the serial ADC receiver
//   en         - accept enable
//   clear      - synchronous window flush (wins over a same-cycle sample)
//   dout       - registered window average (sum >> LOG2N)
//   dout_valid - one-cycle pulse when dout is updated
//   full       - window holds N samples
//
// FSM states:
//   state | meaning
//   FILL  | fewer than N samples accepted since reset/clear, no output
//   RUN   | window full, every accept produces a new average
module adc_avg_filter #(
    parameter int DW    = adc_pkg::DW,
    parameter int LOG2N = adc_pkg::LOG2N
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic          din_tick,
    input  logic          en,
    input  logic          clear,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic          full
);

    localparam int N  = 1 << LOG2N;
    localparam int SW = DW + LOG2N;

    logic               t_q;
    logic               tick_rise;
    logic               accept;
    logic               last_fill;
    logic               to_run;
    logic [0:0]         state_q;
    logic [LOG2N:0]     count_q;
    logic [LOG2N-1:0]   wr_ptr;
    logic [SW-1:0]      sum_q;
    logic [SW-1:0]      sum_next;
    logic [DW-1:0]      samples_q [N];
    logic               upd_q;

    tick_edge_det u_tick (
        .clk    (clk),
        .rst_n  (rst),
        .tick   (din_tick),
        .tick_q (t_q),
        .rise   (tick_rise)
    );

    assign accept    = tick_rise & en & ~clear;
    assign last_fill = (state_q == adc_pkg::FILL) && (count_q == (LOG2N+1)'(N - 1));
    // Accept that leaves the FSM in RUN, including the one completing the fill.
    assign to_run    = accept && ((state_q == adc_pkg::RUN) || last_fill);

    // Oldest sample leaves the window as the new one enters; buffer starts at
    // zero so the same expression also works while filling.
    assign sum_next  = sum_q + SW'(din) - SW'(samples_q[wr_ptr]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                samples_q[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < N; i++) begin
                samples_q[i] <= '0;
            end
        end else if (accept) begin
            samples_q[wr_ptr] <= din;
        end
    end

    // wr_ptr wraps naturally since N is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q   <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            state_q <= adc_pkg::FILL;
        end else if (clear) begin
            sum_q   <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            state_q <= adc_pkg::FILL;
        end else if (accept) begin
            sum_q  <= sum_next;
            wr_ptr <= wr_ptr + 1'b1;
            if (state_q == adc_pkg::FILL) begin
                count_q <= count_q + 1'b1;
                if (last_fill) begin
                    state_q <= adc_pkg::RUN;
                end
            end
        end
    end

    // Output stage: the average is taken one cycle after the accept, from the
    // already-updated sum. clear does not cancel an average already in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            upd_q      <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            upd_q      <= to_run;
            dout_valid <= upd_q;
            if (upd_q) begin
                dout <= sum_q[SW-1:LOG2N];
            end
        end
    end

    assign full = (state_q == adc_pkg::RUN);

endmodule

// File: tb/tb_adc_avg_filter.sv
module tb_adc_avg_filter;

    localparam int DW    = 11;
    localparam int LOG2N = 3;
    localparam int N     = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] din = '0;
    logic          din_tick = 1'b0;
    logic          en = 1'b0;
    logic          clear = 1'b0;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          full;

    always #5 clk = ~clk;

    adc_avg_filter #(.DW(DW), .LOG2N(LOG2N)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_tick   (din_tick),
        .en         (en),
        .clear      (clear),
        .dout       (dout),
        .dout_valid (dout_valid),
        .full       (full)
    );

    typedef struct {
        int unsigned val;
        int unsigned cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        head;
    int unsigned win[$];
    bit          tick_prev = 1'b0;
    int unsigned last_dout = 0;
    int unsigned cyc_cnt = 0;
    int          n_vec = 0;
    int          n_err = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Monitor: compares every presented output against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            n_vec++;
            if (dout_valid) begin
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_valid: dout_valid=1 dout=%0d at cycle %0d, required no pulse", dout, cyc_cnt);
                end else begin
                    head = exp_q.pop_front();
                    if (dout !== DW'(head.val) || cyc_cnt != head.cyc) begin
                        n_err++;
                        $display("FAIL avg_out: dout=%0d at cycle %0d, required %0d at cycle %0d",
                                 dout, cyc_cnt, head.val, head.cyc);
                    end
                    last_dout = head.val;
                end
            end else begin
                if (dout !== DW'(last_dout)) begin
                    n_err++;
                    $display("FAIL dout_hold: dout=%0d, required %0d", dout, last_dout);
                end
                if (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
                    head = exp_q.pop_front();
                    n_err++;
                    $display("FAIL missing_valid: no pulse at cycle %0d, required dout=%0d", cyc_cnt, head.val);
                    last_dout = head.val;
                end
            end
        end
    end

    function automatic int unsigned win_sum();
        int unsigned s = 0;
        foreach (win[i]) s += win[i];
        return s;
    endfunction

    // One clock cycle of stimulus; entered and left just after a falling edge.
    task automatic cyc(input logic [DW-1:0] d, input bit t, input bit e, input bit c);
        n_vec++;
        if (full !== (win.size() == N)) begin
            n_err++;
            $display("FAIL full_flag: full=%0b, required %0b", full, win.size() == N);
        end
        din      = d;
        din_tick = t;
        en       = e;
        clear    = c;
        if (c) begin
            win.delete();
        end else if (t && !tick_prev && e) begin
            win.push_back(int'(d));
            if (win.size() > N) void'(win.pop_front());
            if (win.size() == N) exp_q.push_back('{win_sum() / N, cyc_cnt + 2});
        end
        tick_prev = t;
        @(negedge clk);
    endtask

    task automatic pulse(input logic [DW-1:0] d);
        cyc(d, 1'b1, 1'b1, 1'b0);
        cyc(d, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc('0, 1'b0, 1'b1, 1'b0);
    endtask

    // Asserts reset off the clock edge, checks outputs drop at once, holds it.
    task automatic do_reset(input bit tick_level, input int hold);
        #2;
        rst = 1'b0;
        #1;
        n_vec++;
        if (dout !== '0 || dout_valid !== 1'b0 || full !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: dout=%0d valid=%0b full=%0b, required 0 0 0", dout, dout_valid, full);
        end
        exp_q.delete();
        win.delete();
        last_dout = 0;
        tick_prev = 1'b0;
        din_tick  = tick_level;
        clear     = 1'b0;
        repeat (hold) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #1;
        n_vec++;
        if (dout !== '0 || dout_valid !== 1'b0 || full !== 1'b0) begin
            n_err++;
            $display("FAIL power_on_reset: dout=%0d valid=%0b full=%0b, required 0 0 0", dout, dout_valid, full);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle(2);

        // Eight identical samples, output only on the last one.
        repeat (N) pulse(11'd1000);
        idle(3);

        // Maximum samples, then one zero.
        repeat (N) pulse(11'd2047);
        idle(3);
        pulse(11'd0);
        idle(3);

        // Long tick: a single accept.
        repeat (5) cyc(11'd500, 1'b1, 1'b1, 1'b0);
        idle(3);

        // Clear on a tick edge while in RUN: sample dropped, window refills.
        cyc(11'd123, 1'b1, 1'b1, 1'b1);
        cyc(11'd123, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < N; i++) pulse(DW'(100 + 37 * i));
        idle(3);

        // Enable low over three ticks.
        repeat (3) begin
            cyc(11'd1999, 1'b1, 1'b0, 1'b0);
            cyc(11'd1999, 1'b0, 1'b0, 1'b0);
        end
        idle(3);
        pulse(11'd7);
        idle(3);

        // Clear in the cycle after an accept: pending pulse still issues.
        pulse(11'd300);
        cyc('0, 1'b0, 1'b1, 1'b1);
        idle(4);

        // Fill again, then reset with a pulse pending; tick high at release.
        repeat (N) pulse(11'd1500);
        cyc(11'd900, 1'b1, 1'b1, 1'b0);
        do_reset(1'b1, 3);
        cyc(11'd640, 1'b1, 1'b1, 1'b0);
        cyc(11'd640, 1'b0, 1'b1, 1'b0);
        idle(4);
        repeat (N - 1) pulse(11'd640);
        idle(4);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [DW-1:0] d;
            d = ($urandom_range(0, 3) == 0) ? DW'(2047) : DW'($urandom_range(0, 2047));
            cyc(d, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) != 0), ($urandom_range(0, 59) == 0));
            if ($urandom_range(0, 999) == 0) do_reset(1'($urandom_range(0, 1)), 2);
        end
        idle(5);

        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d outputs still outstanding, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
